shift_add_mul: RTL and testbench

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

---
 rtl/mul_pkg.sv | 16 +
 rtl/shift_add_mul_adder.sv | 28 ++
 rtl/shift_add_mul.sv | 107 ++++++++++
 tb/tb_shift_add_mul.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   mul_state_t : controller states (IDLE, RUN, DONE)
//   MUL_WIDTH   : default operand width in bits
//   MUL_CNT_W   : step-counter width for the default operand width
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_add_mul_adder.sv
// WIDTH-bit ripple-carry adder used as the single adder of the multiplier.
// Ports:
//   a, b : WIDTH-bit addends
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out of the top bit
module shift_add_mul_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: one add-and-shift step per clock.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : multiply request, sampled only in IDLE
//   a, b      : multiplicand / multiplier, captured with an accepted start
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse, product valid in that cycle
//   product   : 2*WIDTH-bit result, held until the next accepted start
//   dbg_state : current controller state (mul_state_t encoding)
//
// Handshake: start is a request that is accepted only on an edge where the
// block is IDLE and rst_n=1; there is no back-pressure and no queuing, so a
// start seen while busy is dropped. done is a single-cycle valid with no
// ready -- the consumer must take product in that cycle or while idle after.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_t         state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Add the multiplicand to the high half only when the current
    // multiplier bit (product LSB) is set; adding zero passes hi through.
    assign add_b = prod[0] ? mcand : '0;

    shift_add_mul_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (prod[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST_STEP) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The adder carry is shifted straight into the product MSB, so the
    // carry lives in prod[2*WIDTH-1] between steps and is never dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        prod  <= {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    prod <= {add_cout, add_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign product   = prod;
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed self-checking bench for shift_add_mul at WIDTH=32.
module tb_shift_add_mul;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     dbg_state;

  int total;
  int bad;
  logic [2*W-1:0] exp_q[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_add_mul #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: pulse start with av/bv, optionally re-pulse start with new
  // operands at cycle repulse_at, then wait for done and check it.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] expv, input int repulse_at);
    int lat;
    int busy_cyc;
    logic [2*W-1:0] e;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(expv);
    step();
    start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cyc++;
      if (lat == repulse_at) begin
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    if (busy) busy_cyc++;
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(LAT));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_product"}, product, e);
    step();
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_product_held"}, product, e);
  endtask

  initial begin
    int n;
    int prev;
    int pulses;
    int extra;

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;

    // reset with start asserted: reset must win
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // first edge with rst_n=1 accepts the start
    rst_n = 1'b1;
    run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
    run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("mul_0xb", 32'd0, 32'hDEAD_BEEF, 64'd0, 0);
    run_op("mul_ax0", 32'h1234_5678, 32'd0, 64'd0, 0);
    run_op("mul_1xmax", 32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0);
    run_op("mul_2p16sq", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0);

    // second start during RUN is ignored
    run_op("mul_ignore", 32'd2, 32'd7, 64'd14, 10);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) extra++;
      step();
    end
    check("ignore_no_second_done", 64'(extra), 64'd0);
    check("ignore_product_held", product, 64'd14);

    // reset mid-RUN at step 16, with start asserted at the same edge
    a = 32'h1000_0000;
    b = 32'h0000_0010;
    start = 1'b1;
    step();
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) extra++;
      step();
    end
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    start = 1'b1;
    a = 32'd6;
    b = 32'd7;
    step();
    if (done) extra++;
    check("abort_no_done", 64'(extra), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check("abort_still_idle", 64'(busy), 64'd0);
    run_op("mul_6x7", 32'd6, 32'd7, 64'd42, 0);

    // start held high: one result every W+2 cycles
    a = 32'h8000_0000;
    b = 32'd2;
    start = 1'b1;
    step();
    n = 1;
    prev = 0;
    pulses = 0;
    while (n <= 105) begin
      if (done) begin
        check("held_product", product, 64'h0000_0001_0000_0000);
        if (prev == 0) check("held_first_latency", 64'(n), 64'(LAT));
        else check("held_interval", 64'(n - prev), 64'(W + 2));
        prev = n;
        pulses++;
      end
      step();
      n++;
    end
    start = 1'b0;
    check("held_pulses", 64'(pulses), 64'd3);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("held_drained", 64'(busy), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit reached");
  end

endmodule
